// File: rtl/layered_objects_mux.sv
// Priority merge of NUM_LAYERS object layers over a background colour, with
// layer-0 collision detection and per-frame publication. Optional: OBJ_MUX_BLINK_EN.
module layered_objects_mux #(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned COLOR_W    = 8,
    parameter int unsigned IDX_W      = $clog2(NUM_LAYERS + 1)
`ifdef OBJ_MUX_BLINK_EN
    , parameter int unsigned BLINK_FRAMES = 16
`endif
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          startOfFrame,
    input  logic [NUM_LAYERS-1:0]         layerDR,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layerRGB,
    input  logic [NUM_LAYERS-1:0]         layerEnable,
`ifdef OBJ_MUX_BLINK_EN
    input  logic [NUM_LAYERS-1:0]         blinkMask,
`endif
    input  logic [COLOR_W-1:0]            backGroundRGB,
    output logic [COLOR_W-1:0]            RGBOut,
    output logic [IDX_W-1:0]              activeLayer,
    output logic [NUM_LAYERS-2:0]         collisionPixel,
    output logic [NUM_LAYERS-2:0]         collisionFrame,
    output logic                          collisionAny
);

    localparam int unsigned HIT_W = NUM_LAYERS - 1;

    logic [NUM_LAYERS-1:0] eff;
    logic [HIT_W-1:0]      hit;
    logic [HIT_W-1:0]      acc;
    logic [HIT_W-1:0]      acc_next;
    logic [COLOR_W-1:0]    win_rgb;
    logic [IDX_W-1:0]      win_idx;

`ifdef OBJ_MUX_BLINK_EN
    localparam int unsigned CNT_W = $clog2(2 * BLINK_FRAMES);

    logic [CNT_W-1:0] frame_cnt;
    logic             blink_hide;

    // Frame counter modulo 2*BLINK_FRAMES; the upper half hides blinking layers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt <= '0;
        end else if (startOfFrame) begin
            if (frame_cnt == CNT_W'(2 * BLINK_FRAMES - 1))
                frame_cnt <= '0;
            else
                frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    assign blink_hide = (frame_cnt >= CNT_W'(BLINK_FRAMES));
    assign eff        = layerDR & layerEnable & ~(blinkMask & {NUM_LAYERS{blink_hide}});
`else
    assign eff        = layerDR & layerEnable;
`endif

    // Lowest-index effective request wins; scanning downward leaves it last.
    always_comb begin
        win_idx = IDX_W'(NUM_LAYERS);
        win_rgb = backGroundRGB;
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (eff[i]) begin
                win_idx = IDX_W'(i);
                win_rgb = layerRGB[i*COLOR_W +: COLOR_W];
            end
        end
    end

    assign hit      = eff[NUM_LAYERS-1:1] & {HIT_W{eff[0]}};
    assign acc_next = acc | hit;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            RGBOut         <= '0;
            activeLayer    <= IDX_W'(NUM_LAYERS);
            collisionPixel <= '0;
        end else begin
            RGBOut         <= win_rgb;
            activeLayer    <= win_idx;
            collisionPixel <= hit;
        end
    end

    // The pixel coincident with startOfFrame still belongs to the closing frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc            <= '0;
            collisionFrame <= '0;
            collisionAny   <= 1'b0;
        end else if (startOfFrame) begin
            acc            <= '0;
            collisionFrame <= acc_next;
            collisionAny   <= |acc_next;
        end else begin
            acc            <= acc_next;
        end
    end

endmodule

// File: tb/tb_layered_objects_mux.sv
// Randomised bench for layered_objects_mux against a frame-level behavioural model,
// with directed literal checks of priority, collisions and frame publication.
module tb_layered_objects_mux;

    localparam int NL = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [3:0]  layerDR;
    logic [31:0] layerRGB;
    logic [3:0]  layerEnable;
    logic [3:0]  blinkMask;
    logic [7:0]  backGroundRGB;
    logic [7:0]  RGBOut;
    logic [2:0]  activeLayer;
    logic [2:0]  collisionPixel;
    logic [2:0]  collisionFrame;
    logic        collisionAny;

    int total = 0;
    int bad   = 0;
    bit check_on = 1'b0;

    always #5 clk = ~clk;

    layered_objects_mux #(
        .NUM_LAYERS(NL),
        .COLOR_W(8)
`ifdef OBJ_MUX_BLINK_EN
        , .BLINK_FRAMES(BF)
`endif
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .layerDR(layerDR),
        .layerRGB(layerRGB),
        .layerEnable(layerEnable),
`ifdef OBJ_MUX_BLINK_EN
        .blinkMask(blinkMask),
`endif
        .backGroundRGB(backGroundRGB),
        .RGBOut(RGBOut),
        .activeLayer(activeLayer),
        .collisionPixel(collisionPixel),
        .collisionFrame(collisionFrame),
        .collisionAny(collisionAny)
    );

    // ---------------- behavioural model ----------------
    logic [7:0] m_rgb;
    int         m_idx;
    logic [2:0] m_pix;
    logic [2:0] m_seen;
    logic [2:0] m_frame;
    logic       m_any;
    int         m_sofs;

    function automatic logic [3:0] visible(logic [3:0] dr, logic [3:0] en, logic [3:0] bm, int sofs);
        logic [3:0] v;
        v = dr & en;
`ifdef OBJ_MUX_BLINK_EN
        if ((sofs % (2 * BF)) >= BF) v = v & ~bm;
`endif
        return v;
    endfunction

    function automatic int winner(logic [3:0] v);
        for (int i = 0; i < NL; i++) if (v[i]) return i;
        return NL;
    endfunction

    function automatic logic [2:0] overlaps(logic [3:0] v);
        logic [2:0] h;
        for (int j = 1; j < NL; j++) h[j-1] = v[0] && v[j];
        return h;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_rgb   <= 8'h00;
            m_idx   <= NL;
            m_pix   <= 3'b000;
            m_seen  <= 3'b000;
            m_frame <= 3'b000;
            m_any   <= 1'b0;
            m_sofs  <= 0;
        end else begin
            logic [3:0] v;
            int w;
            v = visible(layerDR, layerEnable, blinkMask, m_sofs);
            w = winner(v);
            m_idx <= w;
            m_rgb <= (w == NL) ? backGroundRGB : layerRGB[w*8 +: 8];
            m_pix <= overlaps(v);
            if (startOfFrame) begin
                m_frame <= m_seen | overlaps(v);
                m_any   <= (m_seen | overlaps(v)) != 3'b000;
                m_seen  <= 3'b000;
                m_sofs  <= m_sofs + 1;
            end else begin
                m_seen  <= m_seen | overlaps(v);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_on) begin
            total += 5;
            if (RGBOut !== m_rgb) begin
                bad++; $display("FAIL cyc_rgb t=%0t got=%h exp=%h", $time, RGBOut, m_rgb);
            end
            if (activeLayer !== 3'(m_idx)) begin
                bad++; $display("FAIL cyc_idx t=%0t got=%0d exp=%0d", $time, activeLayer, m_idx);
            end
            if (collisionPixel !== m_pix) begin
                bad++; $display("FAIL cyc_pix t=%0t got=%b exp=%b", $time, collisionPixel, m_pix);
            end
            if (collisionFrame !== m_frame) begin
                bad++; $display("FAIL cyc_frame t=%0t got=%b exp=%b", $time, collisionFrame, m_frame);
            end
            if (collisionAny !== m_any) begin
                bad++; $display("FAIL cyc_any t=%0t got=%b exp=%b", $time, collisionAny, m_any);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    initial begin
        resetN        = 1'b1;
        startOfFrame  = 1'b0;
        layerDR       = 4'b0000;
        layerEnable   = 4'b1111;
        blinkMask     = 4'b0000;
        backGroundRGB = 8'h49;
        layerRGB      = {8'h1C, 8'h55, 8'hE0, 8'h03};
        #3 resetN = 1'b0;
        check_on = 1'b1;
        tick(2);
        chk("reset_rgb", 32'(RGBOut), 32'h00);
        chk("reset_idx", 32'(activeLayer), 32'd4);
        resetN = 1'b1;
        tick();
        chk("bg_rgb", 32'(RGBOut), 32'h49);
        chk("bg_idx", 32'(activeLayer), 32'd4);
        chk("bg_frame", 32'(collisionFrame), 32'h0);

        // priority and enable masking
        layerDR = 4'b1010;
        tick();
        chk("prio_rgb", 32'(RGBOut), 32'hE0);
        chk("prio_idx", 32'(activeLayer), 32'd1);
        layerEnable = 4'b1101;
        tick();
        chk("en_rgb", 32'(RGBOut), 32'h1C);
        chk("en_idx", 32'(activeLayer), 32'd3);
        layerEnable = 4'b1111;

        // single-pixel collision 0&2
        layerDR = 4'b0101;
        tick();
        chk("pix_hit", 32'(collisionPixel), 32'b010);
        chk("pix_rgb", 32'(RGBOut), 32'h03);
        layerDR = 4'b0000;
        tick();
        chk("pix_clear", 32'(collisionPixel), 32'b000);
        sof_pulse();
        chk("pub_prev", 32'(collisionFrame), 32'b010);

        // frame A: 0&1 hit then 0&3 hit
        tick(10);
        layerDR = 4'b0011; tick(); layerDR = 4'b0000;
        tick(30);
        chk("hold_mid", 32'(collisionFrame), 32'b010);
        layerDR = 4'b1001; tick(); layerDR = 4'b0000;
        tick(5);
        sof_pulse();
        chk("frameA", 32'(collisionFrame), 32'b101);
        chk("frameA_any", 32'(collisionAny), 32'd1);
        tick(20);
        chk("frameA_hold", 32'(collisionFrame), 32'b101);
        sof_pulse();
        chk("frameB_clr", 32'(collisionFrame), 32'b000);
        chk("frameB_any", 32'(collisionAny), 32'd0);

        // hit coincident with startOfFrame, then an empty frame
        layerDR = 4'b0101; startOfFrame = 1'b1;
        tick();
        layerDR = 4'b0000; startOfFrame = 1'b0;
        chk("coinc", 32'(collisionFrame), 32'b010);
        chk("coinc_any", 32'(collisionAny), 32'd1);
        tick(8);
        sof_pulse();
        chk("coinc_next", 32'(collisionFrame), 32'b000);

        // back-to-back pulses: second publishes only its own hit
        layerDR = 4'b0011; tick(); layerDR = 4'b0000;
        sof_pulse();
        layerDR = 4'b1001; startOfFrame = 1'b1; tick();
        layerDR = 4'b0000; startOfFrame = 1'b0;
        chk("b2b", 32'(collisionFrame), 32'b100);

        // reset mid-frame discards accumulated hits
        layerDR = 4'b0011; tick(); layerDR = 4'b0000;
        resetN = 1'b0; tick(); resetN = 1'b1; tick(3);
        sof_pulse();
        chk("rst_discard", 32'(collisionFrame), 32'b000);

`ifdef OBJ_MUX_BLINK_EN
        resetN = 1'b0; tick(); resetN = 1'b1; tick();
        blinkMask = 4'b0010;
        for (int f = 0; f < 6; f++) begin
            logic vis;
            vis = (f % 4) < 2;
            layerDR = 4'b0011; tick();
            chk("blink_pix", 32'(collisionPixel), vis ? 32'b001 : 32'b000);
            layerDR = 4'b0010; tick();
            chk("blink_idx", 32'(activeLayer), vis ? 32'd1 : 32'd4);
            layerDR = 4'b0000;
            sof_pulse();
            chk("blink_frame", 32'(collisionFrame), vis ? 32'b001 : 32'b000);
        end
        blinkMask = 4'b0000;
`endif

        // randomised phase
        for (int c = 0; c < 3000; c++) begin
            layerDR       = 4'($urandom);
            layerEnable   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
            blinkMask     = 4'($urandom);
            backGroundRGB = 8'($urandom);
            layerRGB      = $urandom;
            startOfFrame  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 599) == 0) resetN = 1'b0;
            else resetN = 1'b1;
            tick();
        end
        resetN = 1'b1;
        startOfFrame = 1'b0;
        tick(2);
        check_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
